// File: rtl/jogo_memoria_pkg.sv
// Shared definitions for the memory game: 5-bit state codes (also decoded by the
// 7-seg state display) and the 8-bit sequence LFSR seed/taps.
package jogo_memoria_pkg;

    typedef enum logic [4:0] {
        INICIAL     = 5'd0,
        PREPARA     = 5'd1,
        PROX_RODADA = 5'd2,
        EXIBE       = 5'd3,
        APAGA       = 5'd4,
        ESPERA      = 5'd5,
        REGISTRA    = 5'd6,
        COMPARA     = 5'd7,
        PROX_JOGADA = 5'd8,
        ACERTOU     = 5'd9,
        ERROU       = 5'd10,
        ESGOTOU     = 5'd11
    } estado_t;

    localparam logic [7:0] LFSR_SEMENTE = 8'hA5;
    // x^8 + x^6 + x^5 + x^4 + 1 -> feedback from bits 7, 5, 4, 3
    localparam logic [7:0] LFSR_TAPS    = 8'hB8;

    function automatic logic [7:0] lfsr_avanca(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/detector_borda.sv
// Rising-edge detector: one-cycle registered pulse when i_sinal goes 0 -> 1.
module detector_borda (
    input  logic clock,
    input  logic reset,
    input  logic i_sinal,
    output logic o_borda
);

    logic r_ant;
    logic r_borda;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ant   <= 1'b0;
            r_borda <= 1'b0;
        end else begin
            r_ant   <= i_sinal;
            r_borda <= i_sinal & ~r_ant;
        end
    end

    assign o_borda = r_borda;

endmodule

// File: rtl/jogo_memoria_param.sv
// Parameterised memory ("Genius") game: generates an LFSR sequence, shows a growing
// prefix of it on the LEDs and checks the player's button presses against it.
module jogo_memoria_param
    import jogo_memoria_pkg::*;
#(
    parameter int unsigned N_BOTOES     = 4,
    parameter int unsigned PROFUNDIDADE = 16,
    parameter int unsigned T_EXIBE      = 1000,
    parameter int unsigned T_TIMEOUT    = 5000
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            jogar,
    input  logic [N_BOTOES-1:0]             botoes,
    input  logic [1:0]                      configuracao,
    output logic [N_BOTOES-1:0]             leds,
    output logic                            ganhou,
    output logic                            perdeu,
    output logic                            timeout,
    output logic                            pronto,
    output logic [$clog2(PROFUNDIDADE):0]   rodada,
    output logic [4:0]                      db_estado
);

    localparam int unsigned LB      = $clog2(N_BOTOES);
    localparam int unsigned AW      = $clog2(PROFUNDIDADE);
    localparam int unsigned RW      = AW + 1;
    localparam int unsigned T_APAGA = (T_EXIBE / 2 > 0) ? T_EXIBE / 2 : 1;
    localparam int unsigned T_MAX   = (T_EXIBE > T_TIMEOUT) ? T_EXIBE : T_TIMEOUT;
    localparam int unsigned TW      = $clog2(T_MAX + 1);

    estado_t               r_estado, w_estado_n;
    logic [LB-1:0]         r_mem [PROFUNDIDADE];
    logic [AW-1:0]         r_addr, w_addr_n;
    logic [AW-1:0]         r_idx, w_idx_n;
    logic [RW-1:0]         r_rodada, w_rodada_n;
    logic [TW-1:0]         r_tmr, w_tmr_n;
    logic [7:0]            r_lfsr, w_lfsr_n;
    logic [7:0]            r_cnt;
    logic                  r_to_hab, w_to_hab_n;
    logic [N_BOTOES-1:0]   r_jogada, w_jogada_n;
    logic [N_BOTOES-1:0]   r_leds, w_leds_n;
    logic                  r_ganhou, r_perdeu, r_timeout, r_pronto;
    logic                  w_we;
    logic                  w_borda;
    logic                  w_ultimo;
    logic [N_BOTOES-1:0]   w_esperado;

    detector_borda u_borda (
        .clock   (clock),
        .reset   (reset),
        .i_sinal (|botoes),
        .o_borda (w_borda)
    );

    assign w_ultimo   = (RW'(r_idx) == r_rodada - RW'(1));
    // Comparing against the one-hot expected value also rejects multi-button presses
    assign w_esperado = N_BOTOES'(1) << r_mem[r_idx];

    always_comb begin
        w_estado_n = r_estado;
        w_addr_n   = r_addr;
        w_idx_n    = r_idx;
        w_rodada_n = r_rodada;
        w_lfsr_n   = r_lfsr;
        w_to_hab_n = r_to_hab;
        w_jogada_n = r_jogada;
        w_we       = 1'b0;
        w_leds_n   = '0;

        case (r_estado)
            INICIAL, ACERTOU, ERROU, ESGOTOU: begin
                if (jogar) begin
                    w_estado_n = PREPARA;
                    w_addr_n   = '0;
                    w_to_hab_n = configuracao[1];
                    w_lfsr_n   = configuracao[0] ? ((r_cnt == 8'd0) ? 8'd1 : r_cnt)
                                                 : LFSR_SEMENTE;
                end
            end
            PREPARA: begin
                w_we     = 1'b1;
                w_lfsr_n = lfsr_avanca(r_lfsr);
                w_addr_n = r_addr + AW'(1);
                if (r_addr == AW'(PROFUNDIDADE - 1)) begin
                    w_estado_n = PROX_RODADA;
                    w_rodada_n = RW'(1);
                end
            end
            PROX_RODADA: begin
                w_idx_n    = '0;
                w_estado_n = EXIBE;
            end
            EXIBE: begin
                if (r_tmr == TW'(T_EXIBE - 1)) w_estado_n = APAGA;
            end
            APAGA: begin
                if (r_tmr == TW'(T_APAGA - 1)) begin
                    if (w_ultimo) begin
                        w_idx_n    = '0;
                        w_estado_n = ESPERA;
                    end else begin
                        w_idx_n    = r_idx + AW'(1);
                        w_estado_n = EXIBE;
                    end
                end
            end
            ESPERA: begin
                // A press wins over a simultaneous timer expiry
                if (w_borda)
                    w_estado_n = REGISTRA;
                else if (r_to_hab && (r_tmr == TW'(T_TIMEOUT - 1)))
                    w_estado_n = ESGOTOU;
            end
            REGISTRA: begin
                w_jogada_n = botoes;
                w_estado_n = COMPARA;
            end
            COMPARA: begin
                if (r_jogada != w_esperado)
                    w_estado_n = ERROU;
                else if (!w_ultimo)
                    w_estado_n = PROX_JOGADA;
                else if (r_rodada == RW'(PROFUNDIDADE))
                    w_estado_n = ACERTOU;
                else begin
                    w_rodada_n = r_rodada + RW'(1);
                    w_estado_n = PROX_RODADA;
                end
            end
            PROX_JOGADA: begin
                w_idx_n    = r_idx + AW'(1);
                w_estado_n = ESPERA;
            end
            default: w_estado_n = INICIAL;
        endcase

        // Shared phase timer restarts on every state change
        w_tmr_n = (w_estado_n != r_estado) ? '0 : r_tmr + TW'(1);

        if (w_estado_n == EXIBE)
            w_leds_n = N_BOTOES'(1) << r_mem[w_idx_n];
        else if (w_estado_n == ESPERA)
            w_leds_n = botoes;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado  <= INICIAL;
            r_addr    <= '0;
            r_idx     <= '0;
            r_rodada  <= '0;
            r_tmr     <= '0;
            r_lfsr    <= '0;
            r_cnt     <= '0;
            r_to_hab  <= 1'b0;
            r_jogada  <= '0;
            r_leds    <= '0;
            r_ganhou  <= 1'b0;
            r_perdeu  <= 1'b0;
            r_timeout <= 1'b0;
            r_pronto  <= 1'b0;
        end else begin
            r_estado  <= w_estado_n;
            r_addr    <= w_addr_n;
            r_idx     <= w_idx_n;
            r_rodada  <= w_rodada_n;
            r_tmr     <= w_tmr_n;
            r_lfsr    <= w_lfsr_n;
            r_cnt     <= r_cnt + 8'd1;
            r_to_hab  <= w_to_hab_n;
            r_jogada  <= w_jogada_n;
            r_leds    <= w_leds_n;
            r_ganhou  <= (w_estado_n == ACERTOU);
            r_perdeu  <= (w_estado_n == ERROU);
            r_timeout <= (w_estado_n == ESGOTOU);
            r_pronto  <= (w_estado_n == ACERTOU) || (w_estado_n == ERROU) ||
                         (w_estado_n == ESGOTOU);
        end
    end

    // Sequence memory: contents are don't-care after reset
    always_ff @(posedge clock) begin
        if (w_we) r_mem[r_addr] <= r_lfsr[LB-1:0];
    end

    assign leds      = r_leds;
    assign ganhou    = r_ganhou;
    assign perdeu    = r_perdeu;
    assign timeout   = r_timeout;
    assign pronto    = r_pronto;
    assign rodada    = r_rodada;
    assign db_estado = r_estado;

endmodule
